// File: rtl/ddfs_pkg.sv
// Shared definitions for the DDFS channel configuration scheduler.
// Holds the default widths, the channel index encodings and the
// scheduler FSM state encoding.
package ddfs_pkg;

    localparam int N_CH = 3;
    localparam int FW_W = 7;
    localparam int FC_W = 3;

    localparam logic [1:0] CH_A = 2'd0;
    localparam logic [1:0] CH_B = 2'd1;
    localparam logic [1:0] CH_C = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_SYNC  = 2'd3
    } state_t;

endpackage

// File: rtl/ddfs_channel_cfg_scheduler_cfg_timeout_counter.sv
// Handshake timeout counter for the config bus.
// Counts cycles while enabled and raises expire when it holds TIMEOUT-1.
// It saturates there until cleared.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (has priority over en)
//   en         : count enable
//   expire     : counter currently at TIMEOUT-1
module cfg_timeout_counter #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt;

    assign expire = (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expire) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ddfs_channel_cfg_scheduler.sv
// DDFS channel configuration scheduler.
// A commit captures a frequency word, a frequency control and a channel mask.
// The selected channels are then written one at a time, lowest index first,
// over a shared valid/ready config bus. A phase_sync pulse follows when at
// least one write succeeded. A commit arriving while busy is held in a
// one-deep pending slot, where a later commit overwrites it.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   commit, fw_in, fc_in,
//   sel_mask              : request and its payload
//   cfg_valid, cfg_ch,
//   cfg_fw, cfg_fc,
//   cfg_ready             : shared config bus handshake
//   phase_sync, done      : one-cycle end-of-sequence pulses
//   busy                  : sequence in progress
//   err_timeout           : sticky per-channel timeout flags
//   active_fw, active_fc  : last successfully written values per channel
module ddfs_channel_cfg_scheduler #(
    parameter int N_CH    = ddfs_pkg::N_CH,
    parameter int FW_W    = ddfs_pkg::FW_W,
    parameter int FC_W    = ddfs_pkg::FC_W,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 commit,
    input  logic [FW_W-1:0]      fw_in,
    input  logic [FC_W-1:0]      fc_in,
    input  logic [N_CH-1:0]      sel_mask,
    output logic                 cfg_valid,
    output logic [1:0]           cfg_ch,
    output logic [FW_W-1:0]      cfg_fw,
    output logic [FC_W-1:0]      cfg_fc,
    input  logic                 cfg_ready,
    output logic                 phase_sync,
    output logic                 busy,
    output logic                 done,
    output logic [N_CH-1:0]      err_timeout,
    output logic [N_CH*FW_W-1:0] active_fw,
    output logic [N_CH*FC_W-1:0] active_fc
);

    import ddfs_pkg::*;

    state_t          state, state_nxt;
    logic [FW_W-1:0] cur_fw, pend_fw, sync_fw;
    logic [FC_W-1:0] cur_fc, pend_fc, sync_fc;
    logic [N_CH-1:0] rem_mask, pend_mask, sync_mask, onehot, rem_next;
    logic            pend_vld, ok_any;
    logic [1:0]      ch_sel;
    logic            xfer, expire, cnt_exp, chan_end, start_idle, start_sync;

    // Lowest set bit of the remaining mask picks the channel on the bus.
    always_comb begin
        ch_sel = CH_A;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (rem_mask[i]) ch_sel = 2'(i);
        end
    end

    assign onehot   = N_CH'(1) << ch_sel;
    assign rem_next = rem_mask & ~onehot;

    assign cfg_valid  = (state == ST_ISSUE) || (state == ST_WAIT);
    assign cfg_ch     = ch_sel;
    assign cfg_fw     = cur_fw;
    assign cfg_fc     = cur_fc;
    assign busy       = (state != ST_IDLE);
    assign done       = (state == ST_SYNC);
    assign phase_sync = (state == ST_SYNC) && ok_any;

    assign xfer     = cfg_valid && cfg_ready;
    assign expire   = cfg_valid && !cfg_ready && cnt_exp;
    assign chan_end = xfer || expire;

    assign start_idle = (state == ST_IDLE) && commit && (|sel_mask);

    // A commit in the SYNC cycle takes precedence over the pending slot,
    // since it would have overwritten it anyway.
    assign sync_fw    = commit ? fw_in : pend_fw;
    assign sync_fc    = commit ? fc_in : pend_fc;
    assign sync_mask  = commit ? sel_mask : pend_mask;
    assign start_sync = (commit || pend_vld) && (|sync_mask);

    // The counter is held clear outside a channel slot and at each channel
    // boundary, so every slot (including ISSUE) begins at zero.
    cfg_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (!cfg_valid || chan_end),
        .en     (cfg_valid),
        .expire (cnt_exp)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start_idle) state_nxt = ST_ISSUE;
            end
            ST_ISSUE, ST_WAIT: begin
                if (chan_end) state_nxt = (|rem_next) ? ST_WAIT : ST_SYNC;
                else          state_nxt = ST_WAIT;
            end
            ST_SYNC: begin
                state_nxt = start_sync ? ST_ISSUE : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_fw      <= '0;
            cur_fc      <= '0;
            rem_mask    <= '0;
            ok_any      <= 1'b0;
            err_timeout <= '0;
            active_fw   <= '0;
            active_fc   <= '0;
            pend_vld    <= 1'b0;
            pend_fw     <= '0;
            pend_fc     <= '0;
            pend_mask   <= '0;
        end else begin
            if (start_idle) begin
                cur_fw      <= fw_in;
                cur_fc      <= fc_in;
                rem_mask    <= sel_mask;
                ok_any      <= 1'b0;
                err_timeout <= '0;
            end else if ((state == ST_SYNC) && start_sync) begin
                cur_fw      <= sync_fw;
                cur_fc      <= sync_fc;
                rem_mask    <= sync_mask;
                ok_any      <= 1'b0;
                err_timeout <= '0;
            end else if (chan_end) begin
                rem_mask <= rem_next;
                if (xfer) begin
                    active_fw[int'(ch_sel)*FW_W +: FW_W] <= cur_fw;
                    active_fc[int'(ch_sel)*FC_W +: FC_W] <= cur_fc;
                    ok_any <= 1'b1;
                end else begin
                    err_timeout[ch_sel] <= 1'b1;
                end
            end

            // The slot is consumed or discarded at SYNC either way.
            if (state == ST_SYNC) begin
                pend_vld <= 1'b0;
            end else if (commit && (state != ST_IDLE)) begin
                pend_vld  <= 1'b1;
                pend_fw   <= fw_in;
                pend_fc   <= fc_in;
                pend_mask <= sel_mask;
            end
        end
    end

endmodule

// File: doc/ddfs_channel_cfg_scheduler.md
Name: ddfs_channel_cfg_scheduler

Overview:
Sequences the programming of up to N_CH DDFS output channels (A/B/C) from a single confirmed frequency word.
- Sits between the keypad frequency-selection logic and the per-channel DDFS cores.
- On a commit strobe it captures fw/freq_control and the channel-select mask, then serialises writes over one shared config bus using a valid/ready handshake.
- After the writes it issues a phase-alignment pulse so the updated channels restart coherently.

Parameters:
N_CH, 3, number of DDFS channels (bit 0 = A, bit 1 = B, bit 2 = C)
FW_W, 7, frequency word width
FC_W, 3, freq_control width
TIMEOUT, 64, max cycles cfg_valid waits for cfg_ready before the channel is skipped (>=2)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous assert, active-low
commit  in  1  one-cycle request to apply fw/freq_control to the selected channels
fw_in  in  FW_W  frequency word to apply
fc_in  in  FC_W  frequency control to apply
sel_mask  in  N_CH  channels to update ({sel_C, sel_B, sel_A})
cfg_valid  out  1  config bus request
cfg_ch  out  2  target channel index
cfg_fw  out  FW_W  word on config bus
cfg_fc  out  FC_W  control on config bus
cfg_ready  in  1  addressed channel accepts
phase_sync  out  1  one-cycle phase-accumulator reset pulse to all channels
busy  out  1  sequence in progress
done  out  1  one-cycle end-of-sequence pulse
err_timeout  out  N_CH  sticky per-channel timeout flags
active_fw  out  N_CH*FW_W  last successfully written fw per channel
active_fc  out  N_CH*FC_W  last successfully written fc per channel

Behaviour:
- Reset: all outputs 0, all shadow registers 0, pending flag clear, FSM in IDLE.
- FSM states: IDLE, ISSUE, WAIT, SYNC.
- IDLE:
  - commit with sel_mask != 0: capture fw_in, fc_in and sel_mask; clear err_timeout; go to ISSUE; busy=1 from the next cycle.
  - commit with sel_mask == 0: ignored; no busy, no done.
- ISSUE: select the lowest set bit of the remaining mask; drive cfg_ch, cfg_fw and cfg_fc; assert cfg_valid; clear the timeout counter; go to WAIT.
- WAIT:
  - cfg_valid stays high and cfg_ch/fw/fc stay stable until a transfer.
  - Transfer = cfg_valid && cfg_ready at a clk edge. On transfer: update active_fw/active_fc slice for cfg_ch, clear that mask bit, mark success.
  - If the counter reaches TIMEOUT-1 without cfg_ready: drop cfg_valid, set err_timeout[cfg_ch], clear that mask bit.
  - Next: if the remaining mask != 0, go directly to the next channel with no idle cycle (cfg_valid stays high, cfg_ch changes). Otherwise go to SYNC.
- SYNC: phase_sync=1 and done=1 for exactly one cycle; phase_sync only if at least one channel succeeded, done always. Then go to IDLE (or directly start the pending request, see below); busy drops.
- Latency with cfg_ready tied high:
  - commit sampled at edge T gives cfg_valid from T+1.
  - One transfer per cycle.
  - For k selected channels, phase_sync/done at cycle T+1+k.
- Commit while busy:
  - Captured into a one-deep pending slot; a later commit overwrites it.
  - Pending is started on the SYNC cycle's next edge, without passing through IDLE.
  - Pending with mask 0 is discarded.
- Simultaneous commit and SYNC: the commit goes to pending and starts next.
- Reset mid-sequence: immediate return to IDLE.
  - cfg_valid deasserts asynchronously.
  - Shadow registers clear; no phase_sync.
- cfg_ready while cfg_valid=0: ignored.

Decomposition:
- Shared package ddfs_pkg: FW_W, FC_W, N_CH, channel index encodings (CH_A=0, CH_B=1, CH_C=2), FSM state encoding.
- One sub-module: cfg_timeout_counter (clear/enable/expire, TIMEOUT parameter).
- Lowest-set-bit priority select stays inline.

Test Plan:
- Ready tied 1; commit fw=7'd45, fc=3'd2, mask=3'b101 -> cfg_ch 0 then 2 on consecutive cycles; active_fw A=C=45, B=0; phase_sync/done at T+3; err_timeout=0.
- Ready held 0 for channel B; mask=3'b010, fw=12 -> cfg_valid high exactly 64 cycles; err_timeout=3'b010; active_fw B unchanged; done=1, phase_sync=0.
- Ready delayed 5 cycles per channel; mask=3'b111 -> cfg_fw stable while waiting; each channel updated once; done at T+1+3*6.
- Second commit (fw=99, mask=3'b001) during a 3-channel sequence, then third commit (fw=100, mask=3'b010) -> after the first done, only channel B gets fw=100; fw=99 never written.
- commit with mask=0 in IDLE -> busy, cfg_valid and done remain 0.
- rst_n low while in WAIT -> cfg_valid=0 immediately; all active_fw/active_fc = 0; no phase_sync after release.
